// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux block.
package stream_demux_pkg;

  // Width of the saturating dropped-beat counter.
  localparam int ERR_CNT_W = 8;

  // Select width for a given channel count. Never narrower than one bit.
  function automatic int sel_width(input int n_out);
    return (n_out <= 2) ? 1 : $clog2(n_out);
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Stream demux bus: one input stream in, N_OUT output streams out.
// master = upstream producer plus downstream consumers, slave = the demux.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = sel_width(N_OUT)
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output buffer for a single demux channel. A load wins over a
// drain on the same cycle, which gives back-to-back throughput.
module stream_demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              v_q, v_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              drain;

  assign drain   = v_q & ready_i;
  assign free_o  = ~v_q | drain;
  assign valid_o = v_q;
  assign data_o  = d_q;

  // Next state: load replaces contents, a bare drain only clears valid.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load_i) begin
      v_d = 1'b1;
      d_d = data_i;
    end else if (drain) begin
      v_d = 1'b0;
    end
  end

  // Slot registers; reset discards any buffered beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-channel backpressure.
// Optional feature macro: STREAM_DEMUX_ERR_EN adds err_pulse/err_count
// reporting for beats dropped because in_sel was out of range.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = sel_width(N_OUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  stream_demux_if.slave        bus
`ifdef STREAM_DEMUX_ERR_EN
  ,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  logic [N_OUT-1:0]             sel_hit;
  logic [N_OUT-1:0]             slot_free;
  logic [N_OUT-1:0]             slot_load;
  logic [N_OUT-1:0]             slot_vld;
  logic [N_OUT-1:0][DATA_W-1:0] slot_data;
  logic                         sel_free;
  logic                         sel_ok;
  logic                         accept;

  // Select decode and ready mux. An out-of-range select hits no channel and
  // is always ready so the beat is consumed and dropped.
  always_comb begin
    sel_hit  = '0;
    sel_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_hit[k] = 1'b1;
        sel_free   = slot_free[k];
      end
    end
  end

  assign sel_ok       = |sel_hit;
  assign bus.in_ready = sel_ok ? sel_free : 1'b1;
  assign accept       = bus.in_valid & bus.in_ready;
  assign slot_load    = sel_hit & {N_OUT{accept}};

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    stream_demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (slot_load[k]),
      .data_i  (bus.in_data),
      .ready_i (bus.out_ready[k]),
      .valid_o (slot_vld[k]),
      .data_o  (slot_data[k]),
      .free_o  (slot_free[k])
    );
  end

  assign bus.out_valid = slot_vld;
  assign bus.out_data  = slot_data;

`ifdef STREAM_DEMUX_ERR_EN
  logic                 drop;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign drop = accept & ~sel_ok;

  // Pulse on every dropped beat; counter sticks at all-ones.
  always_comb begin
    err_pulse_d = drop;
    err_cnt_d   = err_cnt_q;
    if (drop && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Error reporting registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel instance with a per-channel
// scoreboard, plus a 3-channel instance for out-of-range selects.
module tb_stream_demux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  stream_demux_if #(.DATA_W(8), .N_OUT(4)) bus  ();
  stream_demux_if #(.DATA_W(8), .N_OUT(3)) bus3 ();

`ifdef STREAM_DEMUX_ERR_EN
  logic       errp_a, errp_b;
  logic [7:0] errc_a, errc_b;
`endif

  stream_demux #(.DATA_W(8), .N_OUT(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef STREAM_DEMUX_ERR_EN
    ,
    .err_pulse (errp_a),
    .err_count (errc_a)
`endif
  );

  stream_demux #(.DATA_W(8), .N_OUT(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
`ifdef STREAM_DEMUX_ERR_EN
    ,
    .err_pulse (errp_b),
    .err_count (errc_b)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on accepted beat, pop on drained beat (channel order).
  logic [7:0] sbq [4][$];
  logic       hs_last = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) sbq[k].delete();
      hs_last = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          if (sbq[k].size() == 0) chk("sb_underflow", 64'(sbq[k].size()), 64'd1);
          else chk($sformatf("sb_ch%0d", k), bus.out_data[k*8 +: 8], sbq[k].pop_front());
        end
      end
      hs_last = bus.in_valid && bus.in_ready;
      if (hs_last) sbq[bus.in_sel].push_back(bus.in_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = '0; bus.out_ready = '0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.in_sel = '0; bus3.out_ready = '0;
    pulses = 0;

    // Reset and idle
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
`ifdef STREAM_DEMUX_ERR_EN
    chk("rst_errp", 64'(errp_b), 64'd0);
    chk("rst_errc", 64'(errc_b), 64'd0);
`endif
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = 2'(s);
      #1 chk($sformatf("rst_ready_sel%0d", s), 64'(bus.in_ready), 64'd1);
    end

    // Back-to-back stream to channel 2
    cyc();
    bus.out_ready = 4'b1111;
    bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'h11;
    #1 chk("strm_rdy0", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("strm_v0", 64'(bus.out_valid), 64'b0100);
    chk("strm_d0", 64'(bus.out_data[23:16]), 64'h11);
    bus.in_data = 8'h22;
    #1 chk("strm_rdy1", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("strm_v1", 64'(bus.out_valid), 64'b0100);
    chk("strm_d1", 64'(bus.out_data[23:16]), 64'h22);
    bus.in_data = 8'h33;
    #1 chk("strm_rdy2", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("strm_v2", 64'(bus.out_valid), 64'b0100);
    chk("strm_d2", 64'(bus.out_data[23:16]), 64'h33);
    bus.in_valid = 1'b0;
    cyc();
    chk("strm_idle", 64'(bus.out_valid), 64'd0);

    // Channel 1 stalls; channel 3 still gets through
    bus.out_ready = 4'b1101;
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'hA5;
    #1 chk("stall_rdy_a5", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("stall_v1", 64'(bus.out_valid[1]), 64'd1);
    chk("stall_d1", 64'(bus.out_data[15:8]), 64'hA5);
    bus.in_data = 8'h5A;
    #1 chk("stall_rdy_5a", 64'(bus.in_ready), 64'd0);
    cyc();
    chk("stall_hold", 64'(bus.out_data[15:8]), 64'hA5);
    chk("stall_rdy_5a_b", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    cyc();
    bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 8'h3C;
    #1 chk("stall_rdy_3c", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("stall_v3", 64'(bus.out_valid[3]), 64'd1);
    chk("stall_d3", 64'(bus.out_data[31:24]), 64'h3C);
    bus.in_sel = 2'd1; bus.in_data = 8'h5A;
    #1 chk("stall_rdy_5a_c", 64'(bus.in_ready), 64'd0);
    cyc();
    bus.out_ready = 4'b1111;
    #1 chk("stall_release_rdy", 64'(bus.in_ready), 64'd1);
    chk("stall_release_d", 64'(bus.out_data[15:8]), 64'hA5);
    cyc();
    chk("stall_v1_5a", 64'(bus.out_valid[1]), 64'd1);
    chk("stall_d1_5a", 64'(bus.out_data[15:8]), 64'h5A);
    bus.in_valid = 1'b0;
    cyc();
    chk("stall_done", 64'(bus.out_valid), 64'd0);

    // Same-cycle drain and load on channel 0
    bus.out_ready = 4'b1110;
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h01;
    cyc();
    chk("dl_d01", 64'(bus.out_data[7:0]), 64'h01);
    bus.out_ready = 4'b1111; bus.in_data = 8'h02;
    #1 chk("dl_rdy", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("dl_v0", 64'(bus.out_valid[0]), 64'd1);
    chk("dl_d02", 64'(bus.out_data[7:0]), 64'h02);
    bus.in_valid = 1'b0;
    cyc();
    chk("dl_idle", 64'(bus.out_valid), 64'd0);

    // Reset while channels 0 and 3 hold beats
    bus.out_ready = 4'b0000;
    bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h77;
    cyc();
    bus.in_sel = 2'd3; bus.in_data = 8'h88;
    cyc();
    chk("mr_held", 64'(bus.out_valid), 64'b1001);
    reset = 1'b1;
    bus.in_sel = 2'd2; bus.in_data = 8'h99;
    cyc();
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_data", 64'(bus.out_data), 64'd0);
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mr_gone", 64'(bus.out_valid), 64'd0);
    end

    // Random traffic, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (!(bus.in_valid && !hs_last)) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_sel   = 2'($urandom_range(0, 3));
        bus.in_data  = 8'($urandom);
      end
      bus.out_ready = 4'($urandom);
    end
    cyc();
    bus.in_valid = 1'b0; bus.out_ready = 4'b1111;
    cyc(); cyc(); cyc();
    for (int k = 0; k < 4; k++)
      chk($sformatf("sb_left%0d", k), 64'(sbq[k].size()), 64'd0);

    // Out-of-range selects on the 3-channel instance
    bus3.out_ready = 3'b111;
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd3;
    for (int i = 0; i < 4; i++) begin
      bus3.in_data = 8'(i);
      #1 chk("oor_rdy", 64'(bus3.in_ready), 64'd1);
      cyc();
      chk("oor_nov", 64'(bus3.out_valid), 64'd0);
`ifdef STREAM_DEMUX_ERR_EN
      chk("oor_pulse", 64'(errp_b), 64'd1);
`endif
    end
    bus3.in_valid = 1'b0;
    cyc();
    chk("oor_nov_end", 64'(bus3.out_valid), 64'd0);
`ifdef STREAM_DEMUX_ERR_EN
    chk("oor_pulse_end", 64'(errp_b), 64'd0);
    chk("oor_cnt4", 64'(errc_b), 64'd4);
`endif
    bus3.in_valid = 1'b1;
    for (int i = 0; i < 296; i++) begin
      cyc();
      if (bus3.out_valid != 3'b000) chk("oor_long_nov", 64'(bus3.out_valid), 64'd0);
`ifdef STREAM_DEMUX_ERR_EN
      if (errp_b) pulses++;
`endif
    end
    bus3.in_valid = 1'b0;
    cyc();
`ifdef STREAM_DEMUX_ERR_EN
    if (errp_b) pulses++;
    chk("oor_pulses", 64'(pulses), 64'd296);
    chk("oor_cnt_sat", 64'(errc_b), 64'd255);
`endif
    chk("oor_long_end", 64'(bus3.out_valid), 64'd0);

    // In-range beat on the 3-channel instance
    bus3.out_ready = 3'b000;
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd2; bus3.in_data = 8'h42;
    #1 chk("n3_rdy", 64'(bus3.in_ready), 64'd1);
    cyc();
    bus3.in_valid = 1'b0;
    chk("n3_v", 64'(bus3.out_valid), 64'b100);
    chk("n3_d", 64'(bus3.out_data[23:16]), 64'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
